// File: rtl/reg_write_arbiter.sv
// Register-file write-port sequencer: clears all registers after reset, then arbitrates writeback (A) vs queued producer (B).
// Latency: A grant -> write 1 cycle; B handshake -> write 2 cycles minimum.
// Backpressure: A held via a_stall; B valid/ready into a FIFO with no bypass; B forced ahead after STARVE_LIMIT waits.
module reg_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int NUM_REGS     = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_stall,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_regwrite,
    output logic [ADDR_W-1:0] rf_regdst,
    output logic [DATA_W-1:0] rf_writedata,
    output logic              init_busy
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0]        ST_INIT  = 1'b0;
    localparam logic [0:0]        ST_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] LIMIT_C  = WAIT_W'(STARVE_LIMIT);

    logic [0:0]        state;
    logic [ADDR_W-1:0] idx;
    logic              init_done;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic              run;
    logic              fifo_ne;
    logic              starve;
    logic              grant_a;
    logic              grant_b;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign run       = (state == ST_RUN);
    assign fifo_ne   = (cnt != '0);
    assign starve    = fifo_ne && (wait_cnt >= LIMIT_C);
    assign grant_b   = run && (starve || (!a_valid && fifo_ne));
    assign grant_a   = run && !starve && a_valid;
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // Ready comes from the registered count only, so a full FIFO never accepts even while popping.
    assign b_ready   = run && (cnt < DEPTH_C);
    assign a_stall   = !run || starve;
    assign init_busy = !run;
    assign push      = b_valid && b_ready;
    assign pop       = grant_b;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= b_addr;
            fifo_data[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            idx          <= '0;
            init_done    <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            wait_cnt     <= '0;
            rf_regwrite  <= 1'b0;
            rf_regdst    <= '0;
            rf_writedata <= '0;
        end else begin
            if (state == ST_INIT) begin
                // One extra INIT cycle after the last clear keeps init_busy up while that write is on the port.
                if (init_done) begin
                    state       <= ST_RUN;
                    rf_regwrite <= 1'b0;
                end else begin
                    rf_regwrite  <= 1'b1;
                    rf_regdst    <= idx;
                    rf_writedata <= '0;
                    if (idx == LAST_IDX) begin
                        init_done <= 1'b1;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
            end else begin
                if (grant_b) begin
                    rf_regwrite  <= (head_addr != '0);
                    rf_regdst    <= head_addr;
                    rf_writedata <= head_data;
                end else if (grant_a) begin
                    rf_regwrite  <= (a_addr != '0);
                    rf_regdst    <= a_addr;
                    rf_writedata <= a_data;
                end else begin
                    rf_regwrite  <= 1'b0;
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase

            if (!run || !fifo_ne || grant_b) begin
                wait_cnt <= '0;
            end else if (wait_cnt < LIMIT_C) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule
